// File: rtl/if_fetch_queue.sv
`default_nettype none
// ===========================================================================
// if_fetch_queue -- instruction fetch with immediate pre-decode, branch
// prediction and a circular instruction queue. Optional macro: IF_BHT_PREDICT_EN.
// Revision: 1.0
// ===========================================================================
module if_fetch_queue #(
  parameter int          IQ_DEPTH_LOG = 3,
  parameter int          BHT_IDX_W    = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] pc_req,
  output logic        pc_req_valid,
  input  logic [31:0] ins_in,
  input  logic        ins_in_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic        out_pred_taken,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        bht_upd_valid,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken
);

  localparam int PTR_W = IQ_DEPTH_LOG;
  localparam int CNT_W = IQ_DEPTH_LOG + 1;
  localparam int DEPTH = 1 << IQ_DEPTH_LOG;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pc_req_q, pc_req_d;
  logic               pc_req_valid_q, pc_req_valid_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drop_q, drop_d;

  logic [31:0]        iq_ins_q  [DEPTH];
  logic [31:0]        iq_ins_d  [DEPTH];
  logic [31:0]        iq_pc_q   [DEPTH];
  logic [31:0]        iq_pc_d   [DEPTH];
  logic [31:0]        iq_imm_q  [DEPTH];
  logic [31:0]        iq_imm_d  [DEPTH];
  logic               iq_pred_q [DEPTH];
  logic               iq_pred_d [DEPTH];

  logic [31:0]        dec_imm;
  logic               is_jal, is_branch, is_jalr;
  logic               bht_taken;
  logic               pred_taken;
  logic               enq, deq;

  always_comb begin
    dec_imm   = '0;
    is_jal    = 1'b0;
    is_branch = 1'b0;
    is_jalr   = 1'b0;
    case (ins_in[6:0])
      OP_LUI, OP_AUIPC: dec_imm = {ins_in[31:12], 12'b0};
      OP_JAL: begin
        is_jal  = 1'b1;
        dec_imm = {{11{ins_in[31]}}, ins_in[31], ins_in[19:12], ins_in[20], ins_in[30:21], 1'b0};
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        dec_imm   = {{19{ins_in[31]}}, ins_in[31], ins_in[7], ins_in[30:25], ins_in[11:8], 1'b0};
      end
      OP_JALR: begin
        is_jalr = 1'b1;
        dec_imm = {{20{ins_in[31]}}, ins_in[31:20]};
      end
      OP_LOAD:  dec_imm = {{20{ins_in[31]}}, ins_in[31:20]};
      OP_STORE: dec_imm = {{20{ins_in[31]}}, ins_in[31:25], ins_in[11:7]};
      OP_IMM: begin
        if (ins_in[14:12] == 3'b001 || ins_in[14:12] == 3'b101)
          dec_imm = {27'b0, ins_in[24:20]};
        else
          dec_imm = {{20{ins_in[31]}}, ins_in[31:20]};
      end
      default: ;
    endcase
  end

`ifdef IF_BHT_PREDICT_EN
  localparam int BHT_N = 1 << BHT_IDX_W;
  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] bht_rd_idx, bht_wr_idx;
  logic                 unused_bht_pc;

  assign bht_rd_idx    = pc_q[BHT_IDX_W+1:2];
  assign bht_wr_idx    = bht_upd_pc[BHT_IDX_W+1:2];
  assign bht_taken     = bht_q[bht_rd_idx][1];
  assign unused_bht_pc = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

  // Write lands on the clock edge, so a same-cycle read still sees the old counter.
  always_comb begin
    bht_d = bht_q;
    if (rdy && bht_upd_valid) begin
      if (bht_upd_taken) begin
        if (bht_q[bht_wr_idx] != 2'b11) bht_d[bht_wr_idx] = bht_q[bht_wr_idx] + 2'd1;
      end else begin
        if (bht_q[bht_wr_idx] != 2'b00) bht_d[bht_wr_idx] = bht_q[bht_wr_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_bht;
  assign bht_taken  = 1'b0;
  assign unused_bht = ^{bht_upd_valid, bht_upd_pc, bht_upd_taken};
`endif

  assign pred_taken = is_jal | (is_branch & bht_taken);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pc_req_d       = pc_req_q;
    pc_req_valid_d = 1'b0;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    drop_d         = drop_q;
    iq_ins_d       = iq_ins_q;
    iq_pc_d        = iq_pc_q;
    iq_imm_d       = iq_imm_q;
    iq_pred_d      = iq_pred_q;
    enq            = 1'b0;
    deq            = 1'b0;
    if (rdy) begin
      if (redirect_valid) begin
        pc_d    = redirect_pc;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        state_d = S_IDLE;
        // A response still outstanding must be swallowed when it finally arrives.
        if (ins_in_valid)          drop_d = 1'b0;
        else if (state_q == S_WAIT) drop_d = 1'b1;
      end else begin
        deq = out_valid && out_ready;
        case (state_q)
          S_IDLE: begin
            if (count_q < DEPTH_CNT) begin
              pc_req_valid_d = 1'b1;
              pc_req_d       = pc_q;
              state_d        = S_WAIT;
            end
          end
          S_WAIT: begin
            if (ins_in_valid && !drop_q) begin
              enq               = 1'b1;
              iq_ins_d[tail_q]  = ins_in;
              iq_pc_d[tail_q]   = pc_q;
              iq_imm_d[tail_q]  = dec_imm;
              iq_pred_d[tail_q] = pred_taken;
              if (is_jalr) begin
                state_d = S_STALL;
              end else begin
                state_d = S_IDLE;
                pc_d    = pred_taken ? (pc_q + dec_imm) : (pc_q + 32'd4);
              end
            end
          end
          default: ;
        endcase
        if (ins_in_valid && drop_q) begin
          drop_d = 1'b0;
          if (state_q == S_WAIT) state_d = S_IDLE;
        end
        if (enq) tail_d = tail_q + PTR_W'(1);
        if (deq) head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      pc_req_q       <= RESET_PC;
      pc_req_valid_q <= 1'b0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      drop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_req_q       <= pc_req_d;
      pc_req_valid_q <= pc_req_valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      drop_q         <= drop_d;
    end
  end

  // Payload storage needs no reset: out_valid qualifies every read.
  always_ff @(posedge clk) begin
    iq_ins_q  <= iq_ins_d;
    iq_pc_q   <= iq_pc_d;
    iq_imm_q  <= iq_imm_d;
    iq_pred_q <= iq_pred_d;
  end

  assign pc_req         = pc_req_q;
  assign pc_req_valid   = pc_req_valid_q;
  assign out_valid      = (count_q != '0);
  assign out_ins        = iq_ins_q[head_q];
  assign out_pc         = iq_pc_q[head_q];
  assign out_imm        = iq_imm_q[head_q];
  assign out_pred_taken = iq_pred_q[head_q];

endmodule
`default_nettype wire
